// File: rtl/hazard_stall_unit_pkg.sv
// ============================================================================
//  Module   : riscv_hazard_pkg
//  Purpose  : Shared types and constants for the decode-stage hazard unit:
//             FSM state encoding, stall-need codes and default widths.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CNT_W      = 32;

  // FSM state encoding, also visible on the hazard_state output
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } hazard_state_e;

  // Number of stall cycles the instruction in ID still needs
  typedef logic [1:0] stall_need_t;

  localparam stall_need_t STALL_NONE = 2'd0;
  localparam stall_need_t STALL_ONE  = 2'd1;
  localparam stall_need_t STALL_TWO  = 2'd2;

  // Larger of two stall needs; used when several hazard rules fire at once
  function automatic stall_need_t max_need(input stall_need_t a, input stall_need_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_unit_if.sv
// ============================================================================
//  Module   : hazard_stall_unit_if
//  Purpose  : Bundles the decode/EX/MEM hazard inputs and the pipeline
//             control outputs of the hazard stall unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_unit_if #(
  parameter int REG_ADDR_W = riscv_hazard_pkg::DEF_REG_ADDR_W,
  parameter int CNT_W      = riscv_hazard_pkg::DEF_CNT_W
);

  // Instruction in ID
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic                  id_is_branch;
  logic                  id_branch_taken;
  logic                  id_is_jump;

  // Instructions further down the pipe
  logic                  ID_EX_MemRead;
  logic                  ID_EX_RegWrite;
  logic [REG_ADDR_W-1:0] ID_EX_rd;
  logic                  EX_MEM_MemRead;
  logic [REG_ADDR_W-1:0] EX_MEM_rd;
  logic                  mem_busy;

  // Pipeline control
  logic                  pc_write;
  logic                  IF_ID_write;
  logic                  IF_ID_flush;
  logic                  ID_EX_bubble;
  logic                  EX_MEM_write;
  logic                  MEM_WB_write;
  logic [1:0]            hazard_state;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_count;

  // Pipeline side: supplies hazard inputs, consumes control
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_branch,
           id_branch_taken, id_is_jump, ID_EX_MemRead, ID_EX_RegWrite,
           ID_EX_rd, EX_MEM_MemRead, EX_MEM_rd, mem_busy,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_write,
           MEM_WB_write, hazard_state, stall_cycles, flush_count
  );

  // Hazard unit side
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_branch,
           id_branch_taken, id_is_jump, ID_EX_MemRead, ID_EX_RegWrite,
           ID_EX_rd, EX_MEM_MemRead, EX_MEM_rd, mem_busy,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_write,
           MEM_WB_write, hazard_state, stall_cycles, flush_count
  );

endinterface

`default_nettype wire

// File: rtl/hazard_need_calc.sv
// ============================================================================
//  Module   : hazard_need_calc
//  Purpose  : Combinational stall-need calculation (0..2 cycles) for the
//             instruction in ID against the producers in EX and MEM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_need_calc
  import riscv_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_is_branch,
  input  logic                  ID_EX_MemRead,
  input  logic                  ID_EX_RegWrite,
  input  logic [REG_ADDR_W-1:0] ID_EX_rd,
  input  logic                  EX_MEM_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_MEM_rd,
  output stall_need_t           need
);

  // A source depends on a producer only if it is really read and the
  // producer writes a register other than x0
  function automatic logic src_match(
    input logic                  uses,
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] dst
  );
    return uses && (src == dst) && (dst != '0);
  endfunction

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = src_match(id_uses_rs1, id_rs1, ID_EX_rd) |
                     src_match(id_uses_rs2, id_rs2, ID_EX_rd);
  assign w_mem_hit = src_match(id_uses_rs1, id_rs1, EX_MEM_rd) |
                     src_match(id_uses_rs2, id_rs2, EX_MEM_rd);

  // Each rule contributes a need; EX_MEM ALU results are forwarded and add none
  always_comb begin
    need = STALL_NONE;
    if (ID_EX_MemRead && w_ex_hit)
      need = max_need(need, STALL_ONE);
    if (id_is_branch && w_ex_hit && ID_EX_RegWrite && !ID_EX_MemRead)
      need = max_need(need, STALL_ONE);
    if (id_is_branch && w_ex_hit && ID_EX_MemRead)
      need = max_need(need, STALL_TWO);
    if (id_is_branch && w_mem_hit && EX_MEM_MemRead)
      need = max_need(need, STALL_ONE);
  end

endmodule

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// ============================================================================
//  Module   : hazard_stall_unit
//  Purpose  : Decode-stage hazard controller. Decides per cycle whether the
//             front-end advances, stalls, flushes or freezes, and counts
//             stall and flush cycles for performance monitoring.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit
  import riscv_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_unit_if.slave hz
);

  stall_need_t   w_need;
  hazard_state_e r_state, w_state_nxt;
  hazard_state_e r_saved, w_saved_nxt;
  hazard_state_e w_eff_state;
  logic [1:0]    r_cnt, w_cnt_nxt;
  logic          w_stall;
  logic          w_flush;
  logic          w_freeze;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  hazard_need_calc #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_need_calc (
    .id_rs1         (hz.id_rs1),
    .id_rs2         (hz.id_rs2),
    .id_uses_rs1    (hz.id_uses_rs1),
    .id_uses_rs2    (hz.id_uses_rs2),
    .id_is_branch   (hz.id_is_branch),
    .ID_EX_MemRead  (hz.ID_EX_MemRead),
    .ID_EX_RegWrite (hz.ID_EX_RegWrite),
    .ID_EX_rd       (hz.ID_EX_rd),
    .EX_MEM_MemRead (hz.EX_MEM_MemRead),
    .EX_MEM_rd      (hz.EX_MEM_rd),
    .need           (w_need)
  );

  // State, remaining-stall count and pre-freeze state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_saved <= ST_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_saved <= w_saved_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and the stall/flush/freeze decision for this cycle.
  // In FREEZE, the cycle where mem_busy drops already behaves as the saved
  // state, so the memory access completes without an extra dead cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_saved_nxt = r_saved;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    w_freeze    = 1'b0;
    w_eff_state = (r_state == ST_FREEZE) ? r_saved : r_state;

    if (hz.mem_busy) begin
      w_freeze    = 1'b1;
      w_state_nxt = ST_FREEZE;
      w_saved_nxt = w_eff_state;
    end else begin
      case (w_eff_state)
        ST_STALL: begin
          w_stall = 1'b1;
          if (r_cnt <= 2'd1) begin
            w_cnt_nxt   = 2'd0;
            w_state_nxt = ST_RUN;
          end else begin
            w_cnt_nxt   = r_cnt - 2'd1;
            w_state_nxt = ST_STALL;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          if (w_need != STALL_NONE) begin
            w_stall = 1'b1;
            if (w_need == STALL_TWO) begin
              w_state_nxt = ST_STALL;
              w_cnt_nxt   = 2'd1;
            end
          end else if ((hz.id_is_branch && hz.id_branch_taken) || hz.id_is_jump) begin
            w_flush = 1'b1;
          end
        end
      endcase
    end
  end

  // Output decode: reset > freeze > stall > flush > advance
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.IF_ID_write  = 1'b1;
    hz.IF_ID_flush  = 1'b0;
    hz.ID_EX_bubble = 1'b0;
    hz.EX_MEM_write = 1'b1;
    hz.MEM_WB_write = 1'b1;
    if (rst) begin
      hz.pc_write     = 1'b0;
      hz.IF_ID_write  = 1'b0;
      hz.ID_EX_bubble = 1'b1;
      hz.EX_MEM_write = 1'b0;
      hz.MEM_WB_write = 1'b0;
    end else if (w_freeze) begin
      hz.pc_write     = 1'b0;
      hz.IF_ID_write  = 1'b0;
      hz.EX_MEM_write = 1'b0;
      hz.MEM_WB_write = 1'b0;
    end else if (w_stall) begin
      hz.pc_write     = 1'b0;
      hz.IF_ID_write  = 1'b0;
      hz.ID_EX_bubble = 1'b1;
    end else if (w_flush) begin
      hz.IF_ID_flush  = 1'b1;
    end
  end

  // Performance counters, wrapping naturally at their width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall)
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_flush)
        r_flush_count  <= r_flush_count + 1'b1;
    end
  end

  assign hz.hazard_state = r_state;
  assign hz.stall_cycles = r_stall_cycles;
  assign hz.flush_count  = r_flush_count;

endmodule

`default_nettype wire
